instr_fetch_unit: RTL and testbench

//  Fetch stage of the 24-bit multi-cycle CPU; directly upstream of the control unit.

---
 rtl/cpu24_pkg.sv | 39 +++
 rtl/instr_fetch_unit_if.sv | 28 ++
 rtl/instr_fetch_unit_pc_next.sv | 26 ++
 rtl/instr_fetch_unit.sv | 112 +++++++++++
 tb/tb_instr_fetch_unit.sv | 330 +++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/cpu24_pkg.sv
// Shared definitions for the 24-bit multi-cycle CPU: opcodes, function codes,
// instruction field positions and the fetch-stage state encoding.
package cpu24_pkg;

    // Opcodes carried in IR[23:20]
    localparam logic [3:0] OP_ADDI  = 4'b0001;
    localparam logic [3:0] OP_LS    = 4'b0010;
    localparam logic [3:0] OP_SS    = 4'b0011;
    localparam logic [3:0] OP_BEQ   = 4'b0100;
    localparam logic [3:0] OP_RTYPE = 4'b0110;
    localparam logic [3:0] OP_HALT  = 4'b1111;

    // R-type function codes carried in IR[3:0]
    localparam logic [3:0] FUNCT_MUL = 4'b0101;

    // Instruction field bit positions (24-bit word)
    localparam int OPCODE_HI = 23;
    localparam int OPCODE_LO = 20;
    localparam int RS_HI     = 19;
    localparam int RS_LO     = 16;
    localparam int RT_HI     = 15;
    localparam int RT_LO     = 12;
    localparam int RD_HI     = 11;
    localparam int RD_LO     = 8;
    localparam int FUNCT_HI  = 3;
    localparam int FUNCT_LO  = 0;
    localparam int IMM_HI    = 11;
    localparam int IMM_LO    = 0;
    localparam int IMM_W     = 12;

    // Fetch-stage state encoding
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_VALID = 2'd2,
        ST_HALT  = 2'd3
    } fetch_state_t;

endpackage

// File: rtl/instr_fetch_unit_if.sv
// Instruction-memory port between the fetch unit (master) and the memory (slave).
// Handshake: the master raises imem_req with imem_addr and holds both stable
// until the slave returns imem_ack=1 together with valid imem_rdata for one
// cycle; ack may arrive in the first request cycle. Ack while no request is
// outstanding carries no meaning and is ignored by the master.
interface instr_fetch_unit_if #(
    parameter int AW = 16,
    parameter int IW = 24
);
    logic          imem_req;
    logic [AW-1:0] imem_addr;
    logic          imem_ack;
    logic [IW-1:0] imem_rdata;

    modport master (
        output imem_req,
        output imem_addr,
        input  imem_ack,
        input  imem_rdata
    );

    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_ack,
        output imem_rdata
    );
endinterface

// File: rtl/instr_fetch_unit_pc_next.sv
// Next-PC computation: sequential PC+1 or branch target PC+1+sext(imm),
// both modulo 2^AW. Purely combinational so it can be reused by other stages.
module pc_next_logic
    import cpu24_pkg::*;
#(
    parameter int AW = 16
) (
    input  logic [AW-1:0]    pc,
    input  logic [IMM_W-1:0] imm,
    input  logic             branchTaken,
    output logic [AW-1:0]    pcNext
);

    logic [AW-1:0] pcPlusOne;
    logic [AW-1:0] immExt;
    logic [AW-1:0] branchTarget;

    // Sequential and branch candidates; wrap-around is the natural AW-bit overflow
    always_comb begin
        pcPlusOne    = pc + AW'(1);
        immExt       = {{(AW-IMM_W){imm[IMM_W-1]}}, imm};
        branchTarget = pcPlusOne + immExt;
        pcNext       = branchTaken ? branchTarget : pcPlusOne;
    end

endmodule

// File: rtl/instr_fetch_unit.sv
// Fetch stage: holds the PC, fetches one word per instruction over the
// req/ack memory port, latches it in the IR and presents the decoded fields.
// The PC advances only when the datapath signals completion of the current
// instruction; HALT parks the unit until reset.
module instr_fetch_unit
    import cpu24_pkg::*;
#(
    parameter int            AW       = 16,
    parameter int            IW       = 24,
    parameter logic [AW-1:0] RESET_PC = '0
) (
    input  logic                Clock,
    input  logic                Reset_n,
    input  logic                run,
    instr_fetch_unit_if.master  imem,
    output logic                instr_valid,
    output logic [IW-1:0]       instr,
    output logic [3:0]          OPCODE,
    output logic [3:0]          rs,
    output logic [3:0]          rt,
    output logic [3:0]          rd,
    output logic [3:0]          Funct,
    output logic [IMM_W-1:0]    imm,
    output logic [AW-1:0]       pc,
    input  logic                instr_done,
    input  logic                branch_taken,
    output logic                halted,
    output fetch_state_t        dbgState
);

    fetch_state_t  stateReg;
    logic [AW-1:0] pcReg;
    logic [IW-1:0] irReg;
    logic          reqReg;
    logic          validReg;
    logic          haltedReg;
    logic [AW-1:0] pcNext;

    pc_next_logic #(.AW(AW)) u_pc_next (
        .pc          (pcReg),
        .imm         (irReg[IMM_HI:IMM_LO]),
        .branchTaken (branch_taken),
        .pcNext      (pcNext)
    );

    // Fetch FSM with registered request/valid/halted flags; the PC only moves
    // on a completed non-HALT instruction, so it always names the IR's address
    always_ff @(posedge Clock or negedge Reset_n) begin
        if (!Reset_n) begin
            stateReg  <= ST_IDLE;
            pcReg     <= RESET_PC;
            irReg     <= '0;
            reqReg    <= 1'b0;
            validReg  <= 1'b0;
            haltedReg <= 1'b0;
        end else begin
            case (stateReg)
                ST_IDLE: begin
                    if (run) begin
                        stateReg <= ST_FETCH;
                        reqReg   <= 1'b1;
                    end
                end
                ST_FETCH: begin
                    if (imem.imem_ack) begin
                        irReg    <= imem.imem_rdata;
                        reqReg   <= 1'b0;
                        validReg <= 1'b1;
                        stateReg <= ST_VALID;
                    end
                end
                ST_VALID: begin
                    if (instr_done) begin
                        validReg <= 1'b0;
                        if (irReg[OPCODE_HI:OPCODE_LO] == OP_HALT) begin
                            haltedReg <= 1'b1;
                            stateReg  <= ST_HALT;
                        end else begin
                            pcReg    <= pcNext;
                            reqReg   <= 1'b1;
                            stateReg <= ST_FETCH;
                        end
                    end
                end
                ST_HALT: begin
                    stateReg <= ST_HALT;
                end
                default: begin
                    stateReg <= ST_IDLE;
                end
            endcase
        end
    end

    // Outputs come straight from registers; no input-to-output paths
    always_comb begin
        imem.imem_req  = reqReg;
        imem.imem_addr = pcReg;
        instr_valid    = validReg;
        instr          = irReg;
        OPCODE         = irReg[OPCODE_HI:OPCODE_LO];
        rs             = irReg[RS_HI:RS_LO];
        rt             = irReg[RT_HI:RT_LO];
        rd             = irReg[RD_HI:RD_LO];
        Funct          = irReg[FUNCT_HI:FUNCT_LO];
        imm            = irReg[IMM_HI:IMM_LO];
        pc             = pcReg;
        halted         = haltedReg;
        dbgState       = stateReg;
    end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Bench for instr_fetch_unit: directed instruction stream with hand-computed
// fetch addresses and decoded fields, plus a second instance reset to 0xFFFF
// for PC wrap-around.
module tb_instr_fetch_unit;
  import cpu24_pkg::*;

  // ---------------- clock / reset ----------------
  logic Clock = 1'b0;
  always #5 Clock = ~Clock;
  logic Reset_n;

  // ---------------- DUT0 (RESET_PC = 0) ----------------
  logic         run0, done0, bt0;
  logic         valid0, halted0;
  logic [23:0]  instr0;
  logic [3:0]   op0, rs0, rt0, rd0, fn0;
  logic [11:0]  imm0;
  logic [15:0]  pc0;
  fetch_state_t st0;
  instr_fetch_unit_if #(.AW(16), .IW(24)) if0 ();

  instr_fetch_unit #(.AW(16), .IW(24), .RESET_PC(16'h0000)) u_dut0 (
    .Clock(Clock), .Reset_n(Reset_n), .run(run0), .imem(if0.master),
    .instr_valid(valid0), .instr(instr0), .OPCODE(op0), .rs(rs0), .rt(rt0),
    .rd(rd0), .Funct(fn0), .imm(imm0), .pc(pc0), .instr_done(done0),
    .branch_taken(bt0), .halted(halted0), .dbgState(st0)
  );

  // ---------------- DUT1 (RESET_PC = 0xFFFF) ----------------
  logic         run1, done1, bt1;
  logic         valid1, halted1;
  logic [23:0]  instr1;
  logic [3:0]   op1, rs1, rt1, rd1, fn1;
  logic [11:0]  imm1;
  logic [15:0]  pc1;
  fetch_state_t st1;
  instr_fetch_unit_if #(.AW(16), .IW(24)) if1 ();

  instr_fetch_unit #(.AW(16), .IW(24), .RESET_PC(16'hFFFF)) u_dut1 (
    .Clock(Clock), .Reset_n(Reset_n), .run(run1), .imem(if1.master),
    .instr_valid(valid1), .instr(instr1), .OPCODE(op1), .rs(rs1), .rt(rt1),
    .rd(rd1), .Funct(fn1), .imm(imm1), .pc(pc1), .instr_done(done1),
    .branch_taken(bt1), .halted(halted1), .dbgState(st1)
  );

  // ---------------- scoreboard ----------------
  int checks = 0;
  int errors = 0;
  logic [15:0] exp_addr_q[$];
  logic [71:0] exp_dec_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Expected decode record: {pc, instr, opcode, rs, rt, rd, funct, imm}
  function automatic logic [71:0] dec(input logic [15:0] p, input logic [23:0] w,
                                      input logic [3:0] op, input logic [3:0] s,
                                      input logic [3:0] t, input logic [3:0] d,
                                      input logic [3:0] fn, input logic [11:0] im);
    return {p, w, op, s, t, d, fn, im};
  endfunction

  // Monitor on DUT0: every new request and every new valid instruction pops the queues
  initial begin
    logic        prev_req;
    logic        prev_valid;
    logic [15:0] cur_addr;
    logic [71:0] e;
    prev_req = 1'b0;
    prev_valid = 1'b0;
    cur_addr = '0;
    forever begin
      @(negedge Clock);
      if (!Reset_n) begin
        prev_req = 1'b0;
        prev_valid = 1'b0;
      end else begin
        if (if0.imem_req && !prev_req) begin
          if (exp_addr_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_req: got request at addr 0x%0h expected none", if0.imem_addr);
            cur_addr = if0.imem_addr;
          end else begin
            cur_addr = exp_addr_q.pop_front();
            check("req_addr", 32'(if0.imem_addr), 32'(cur_addr));
          end
        end else if (if0.imem_req) begin
          check("addr_stable", 32'(if0.imem_addr), 32'(cur_addr));
        end
        if (valid0 && !prev_valid) begin
          if (exp_dec_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_valid: got instr 0x%0h expected none", instr0);
          end else begin
            e = exp_dec_q.pop_front();
            check("pc",     32'(pc0),    32'(e[71:56]));
            check("instr",  32'(instr0), 32'(e[55:32]));
            check("opcode", 32'(op0),    32'(e[31:28]));
            check("rs",     32'(rs0),    32'(e[27:24]));
            check("rt",     32'(rt0),    32'(e[23:20]));
            check("rd",     32'(rd0),    32'(e[19:16]));
            check("funct",  32'(fn0),    32'(e[15:12]));
            check("imm",    32'(imm0),   32'(e[11:0]));
          end
        end
        prev_req = if0.imem_req;
        prev_valid = valid0;
      end
    end
  end

  // ---------------- driver tasks (all called at a negedge) ----------------
  task automatic wait_req0(output bit ok);
    ok = if0.imem_req;
    for (int i = 0; i < 50 && !ok; i++) begin
      @(negedge Clock);
      ok = if0.imem_req;
    end
    if (!ok) begin
      checks++;
      errors++;
      $display("FAIL req_timeout: got no imem_req expected one within 50 cycles");
    end
  endtask

  task automatic fetch0(input int waits, input logic [23:0] data);
    bit ok;
    wait_req0(ok);
    repeat (waits) @(negedge Clock);
    if0.imem_ack = 1'b1;
    if0.imem_rdata = data;
    @(negedge Clock);
    if0.imem_ack = 1'b0;
    if0.imem_rdata = '0;
    check("valid_latency", 32'(valid0), 32'd1);
  endtask

  task automatic retire0(input logic bt, input bit exp_req);
    done0 = 1'b1;
    bt0 = bt;
    @(negedge Clock);
    done0 = 1'b0;
    bt0 = 1'b0;
    if (exp_req) check("req_after_done", 32'(if0.imem_req), 32'd1);
  endtask

  task automatic wait_req1(output bit ok);
    ok = if1.imem_req;
    for (int i = 0; i < 50 && !ok; i++) begin
      @(negedge Clock);
      ok = if1.imem_req;
    end
    if (!ok) begin
      checks++;
      errors++;
      $display("FAIL req1_timeout: got no imem_req expected one within 50 cycles");
    end
  endtask

  // Watchdog
  initial begin
    #100000;
    $display("FAIL watchdog: got no end of test expected finish before 100us");
    $fatal(1);
  end

  // ---------------- stimulus ----------------
  initial begin
    bit ok;
    Reset_n = 1'b0;
    run0 = 0; done0 = 0; bt0 = 0;
    run1 = 0; done1 = 0; bt1 = 0;
    if0.imem_ack = 0; if0.imem_rdata = '0;
    if1.imem_ack = 0; if1.imem_rdata = '0;
    repeat (3) @(negedge Clock);
    Reset_n = 1'b1;

    // Reset state with run low
    repeat (5) @(negedge Clock);
    check("rst_req",    32'(if0.imem_req), 32'd0);
    check("rst_valid",  32'(valid0),       32'd0);
    check("rst_halted", 32'(halted0),      32'd0);
    check("rst_pc",     32'(pc0),          32'd0);
    check("rst_state",  32'(st0),          32'(ST_IDLE));

    // R-type fetch with two wait cycles
    exp_addr_q.push_back(16'h0000);
    exp_dec_q.push_back(dec(16'h0000, 24'h612305, 4'h6, 4'h1, 4'h2, 4'h3, 4'h5, 12'h305));
    run0 = 1'b1;
    fetch0(2, 24'h612305);
    run0 = 1'b0;
    exp_addr_q.push_back(16'h0001);
    retire0(1'b0, 1'b1);

    // BEQ at 1, imm=3, taken -> 5
    exp_dec_q.push_back(dec(16'h0001, 24'h400003, 4'h4, 4'h0, 4'h0, 4'h0, 4'h3, 12'h003));
    fetch0(0, 24'h400003);
    exp_addr_q.push_back(16'h0005);
    retire0(1'b1, 1'b1);

    // BEQ at 5, imm=0xFFE (-2), taken -> 4
    exp_dec_q.push_back(dec(16'h0005, 24'h412FFE, 4'h4, 4'h1, 4'h2, 4'hF, 4'hE, 12'hFFE));
    fetch0(1, 24'h412FFE);
    exp_addr_q.push_back(16'h0004);
    retire0(1'b1, 1'b1);
    check("branch_back_pc", 32'(pc0), 32'h4);

    // ADDI at 4 -> 5
    exp_dec_q.push_back(dec(16'h0004, 24'h100000, 4'h1, 4'h0, 4'h0, 4'h0, 4'h0, 12'h000));
    fetch0(0, 24'h100000);
    exp_addr_q.push_back(16'h0005);
    retire0(1'b0, 1'b1);

    // Same BEQ at 5, not taken -> 6
    exp_dec_q.push_back(dec(16'h0005, 24'h412FFE, 4'h4, 4'h1, 4'h2, 4'hF, 4'hE, 12'hFFE));
    fetch0(0, 24'h412FFE);
    exp_addr_q.push_back(16'h0006);
    retire0(1'b0, 1'b1);
    check("not_taken_pc", 32'(pc0), 32'h6);

    // instr_done/branch_taken during FETCH are ignored
    done0 = 1'b1; bt0 = 1'b1;
    @(negedge Clock);
    done0 = 1'b0; bt0 = 1'b0;
    check("done_in_fetch_pc",  32'(pc0), 32'h6);
    check("done_in_fetch_req", 32'(if0.imem_req), 32'd1);

    // Unknown opcode E passes through; stray ack and lone branch_taken in VALID ignored
    exp_dec_q.push_back(dec(16'h0006, 24'hE12345, 4'hE, 4'h1, 4'h2, 4'h3, 4'h5, 12'h345));
    fetch0(0, 24'hE12345);
    if0.imem_ack = 1'b1; if0.imem_rdata = 24'hABCDEF;
    bt0 = 1'b1;
    @(negedge Clock);
    if0.imem_ack = 1'b0; if0.imem_rdata = '0;
    bt0 = 1'b0;
    check("ack_in_valid_ir",   32'(instr0), 32'hE12345);
    check("bt_alone_pc",       32'(pc0),    32'h6);
    check("bt_alone_valid",    32'(valid0), 32'd1);
    exp_addr_q.push_back(16'h0007);
    retire0(1'b0, 1'b1);

    // HALT at 7
    exp_dec_q.push_back(dec(16'h0007, 24'hF00000, 4'hF, 4'h0, 4'h0, 4'h0, 4'h0, 12'h000));
    fetch0(0, 24'hF00000);
    retire0(1'b0, 1'b0);
    check("halt_halted", 32'(halted0),      32'd1);
    check("halt_valid",  32'(valid0),       32'd0);
    check("halt_req",    32'(if0.imem_req), 32'd0);
    check("halt_state",  32'(st0),          32'(ST_HALT));
    run0 = 1'b1;
    repeat (6) begin
      if0.imem_ack = 1'b1; if0.imem_rdata = 24'h123456;
      @(negedge Clock);
    end
    if0.imem_ack = 1'b0; if0.imem_rdata = '0;
    run0 = 1'b0;
    check("halt_sticky",   32'(halted0),      32'd1);
    check("halt_no_req",   32'(if0.imem_req), 32'd0);
    check("halt_pc",       32'(pc0),          32'h7);
    check("halt_ir",       32'(instr0),       32'hF00000);

    // DUT1: PC wrap from 0xFFFF
    run1 = 1'b1;
    wait_req1(ok);
    run1 = 1'b0;
    check("wrap_first_addr", 32'(if1.imem_addr), 32'hFFFF);
    if1.imem_ack = 1'b1; if1.imem_rdata = 24'h100000;
    @(negedge Clock);
    if1.imem_ack = 1'b0; if1.imem_rdata = '0;
    check("wrap_valid", 32'(valid1), 32'd1);
    done1 = 1'b1;
    @(negedge Clock);
    done1 = 1'b0;
    check("wrap_inc_req",  32'(if1.imem_req),  32'd1);
    check("wrap_inc_addr", 32'(if1.imem_addr), 32'h0000);
    // BEQ at 0 with imm=-2 taken -> 0xFFFF
    if1.imem_ack = 1'b1; if1.imem_rdata = 24'h400FFE;
    @(negedge Clock);
    if1.imem_ack = 1'b0; if1.imem_rdata = '0;
    done1 = 1'b1; bt1 = 1'b1;
    @(negedge Clock);
    done1 = 1'b0; bt1 = 1'b0;
    check("wrap_branch_addr", 32'(if1.imem_addr), 32'hFFFF);

    // Reset during FETCH at pc=3
    Reset_n = 1'b0;
    @(negedge Clock);
    Reset_n = 1'b1;
    check("rerst_pc",    32'(pc0), 32'h0);
    check("rerst_state", 32'(st0), 32'(ST_IDLE));
    exp_addr_q.push_back(16'h0000);
    exp_dec_q.push_back(dec(16'h0000, 24'h400002, 4'h4, 4'h0, 4'h0, 4'h0, 4'h2, 12'h002));
    run0 = 1'b1;
    fetch0(0, 24'h400002);
    run0 = 1'b0;
    exp_addr_q.push_back(16'h0003);
    retire0(1'b1, 1'b1);
    check("pre_reset_addr", 32'(if0.imem_addr), 32'h3);
    #2;
    Reset_n = 1'b0;
    #1;
    check("async_req_drop", 32'(if0.imem_req), 32'd0);
    if0.imem_ack = 1'b1; if0.imem_rdata = 24'hABCDEF;
    @(negedge Clock);
    @(negedge Clock);
    if0.imem_ack = 1'b0; if0.imem_rdata = '0;
    Reset_n = 1'b1;
    @(negedge Clock);
    check("post_rst_pc",    32'(pc0),          32'h0);
    check("post_rst_state", 32'(st0),          32'(ST_IDLE));
    check("post_rst_ir",    32'(instr0),       32'h0);
    check("post_rst_req",   32'(if0.imem_req), 32'd0);
    check("post_rst_valid", 32'(valid0),       32'd0);

    repeat (3) @(negedge Clock);
    check("addr_q_drained", 32'(exp_addr_q.size()), 32'd0);
    check("dec_q_drained",  32'(exp_dec_q.size()),  32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
